// File: rtl/traffic_light_ctrl_param_pkg.sv
// Shared encodings for the parametrised intersection controller: lamp codes,
// controller states and movement-permission bit positions.
package traffic_pkg;

   localparam logic [1:0] LAMP_RED    = 2'b00;
   localparam logic [1:0] LAMP_GREEN  = 2'b01;
   localparam logic [1:0] LAMP_YELLOW = 2'b10;

   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_WALK    = 2'd1,
      ST_GREEN   = 2'd2,
      ST_YELLOW  = 2'd3
   } state_e;

   localparam int MOVE_LEFT  = 0;
   localparam int MOVE_RIGHT = 1;
   localparam int MOVE_OPP   = 2;

   localparam logic [2:0] MOVE_ALL = 3'((1 << MOVE_LEFT) | (1 << MOVE_RIGHT) | (1 << MOVE_OPP));

endpackage

// File: rtl/traffic_light_ctrl_param_phase_timer.sv
// Phase down-counter: load has priority, hold freezes the count, and done
// flags the last cycle of the current phase (count == 0).
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             hold_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (!hold_i && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// N-approach round-robin signal controller with all-red clearance and latched
// pedestrian walk. Define EMERG_PREEMPT_EN to enable emergency pre-emption.
module traffic_light_ctrl_param
   import traffic_pkg::*;
#(
   parameter int N_DIR      = 4,
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 2,
   parameter int ALLRED_CYC = 1,
   parameter int WALK_CYC   = 4,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_DIR-1:0]   ped_req,
   input  logic               emerg,
   input  logic [2:0]         emerg_dir,
   output logic [2*N_DIR-1:0] lamp,
   output logic [3*N_DIR-1:0] move_en,
   output logic [N_DIR-1:0]   ped_walk,
   output logic [2:0]         active_dir
);

   localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);
   localparam logic [2:0]       DIR_LAST  = 3'(N_DIR - 1);

   state_e             state_q, state_d;
   logic [2:0]         dir_q, dir_d;
   logic [N_DIR-1:0]   pend_q, pend_d;
   logic [N_DIR-1:0]   walk_bits_q, walk_bits_d;
   logic               walk_done_q, walk_done_d;
   logic [2*N_DIR-1:0] lamp_q, lamp_d;
   logic [3*N_DIR-1:0] move_q, move_d;
   logic [N_DIR-1:0]   ped_walk_q, ped_walk_d;

   logic               tmr_load, tmr_hold, tmr_done;
   logic [CNT_W-1:0]   tmr_val;
   logic               skip_walk;

`ifdef EMERG_PREEMPT_EN
   logic       emerg_v;
   logic       pre_q, pre_d;
   logic [2:0] pre_dir_q, pre_dir_d;

   assign emerg_v   = emerg && (int'(emerg_dir) < N_DIR);
   assign skip_walk = pre_q || emerg_v;
`else
   logic unused_emerg;
   assign unused_emerg = ^{emerg, emerg_dir};
   assign skip_walk    = 1'b0;
`endif

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .hold_i     (tmr_hold),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      pend_d      = pend_q | ped_req;
      walk_bits_d = walk_bits_q;
      walk_done_d = walk_done_q;
      tmr_load    = 1'b0;
      tmr_val     = ALLRED_LD;
      tmr_hold    = 1'b0;
`ifdef EMERG_PREEMPT_EN
      pre_d       = pre_q;
      pre_dir_d   = pre_dir_q;
`endif
      case (state_q)
         ST_ALL_RED: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               if (pend_q != '0 && !walk_done_q && !skip_walk) begin
                  state_d     = ST_WALK;
                  tmr_val     = WALK_LD;
                  walk_bits_d = pend_q;
                  // served bits clear, but a request in this same cycle is kept
                  pend_d      = ped_req;
               end else begin
                  state_d     = ST_GREEN;
                  tmr_val     = GREEN_LD;
                  walk_done_d = 1'b0;
`ifdef EMERG_PREEMPT_EN
                  pre_d = 1'b0;
                  if (emerg_v) dir_d = emerg_dir;
`endif
               end
            end
         end
         ST_WALK: begin
`ifdef EMERG_PREEMPT_EN
            if (emerg_v) begin
               state_d     = ST_ALL_RED;
               tmr_load    = 1'b1;
               tmr_val     = ALLRED_LD;
               walk_done_d = 1'b1;
               dir_d       = emerg_dir;
               pre_d       = 1'b1;
            end else
`endif
            if (tmr_done) begin
               state_d     = ST_ALL_RED;
               tmr_load    = 1'b1;
               tmr_val     = ALLRED_LD;
               walk_done_d = 1'b1;
            end
         end
         ST_GREEN: begin
`ifdef EMERG_PREEMPT_EN
            if (emerg_v && dir_q == emerg_dir) begin
               tmr_hold = 1'b1;
            end else if (emerg_v) begin
               state_d   = ST_YELLOW;
               tmr_load  = 1'b1;
               tmr_val   = YELLOW_LD;
               pre_d     = 1'b1;
               pre_dir_d = emerg_dir;
            end else
`endif
            if (tmr_done) begin
               state_d  = ST_YELLOW;
               tmr_load = 1'b1;
               tmr_val  = YELLOW_LD;
            end
         end
         ST_YELLOW: begin
            if (tmr_done) begin
               state_d  = ST_ALL_RED;
               tmr_load = 1'b1;
               tmr_val  = ALLRED_LD;
               dir_d    = (dir_q == DIR_LAST) ? 3'd0 : dir_q + 3'd1;
`ifdef EMERG_PREEMPT_EN
               if (pre_q) dir_d = pre_dir_q;
`endif
            end
         end
         default: state_d = ST_ALL_RED;
      endcase
      // reset reloads the all-red clearance so the first green is ALLRED_CYC away
      if (!rst) begin
         tmr_load = 1'b1;
         tmr_val  = ALLRED_LD;
      end
   end

   // Output decode from next state so lamps change in the same cycle as the state register.
   genvar gi;
   generate
      for (gi = 0; gi < N_DIR; gi++) begin : g_dec
         logic sel;
         assign sel = (dir_d == 3'(gi));
         assign lamp_d[2*gi +: 2] = !sel                  ? LAMP_RED    :
                                    (state_d == ST_GREEN)  ? LAMP_GREEN  :
                                    (state_d == ST_YELLOW) ? LAMP_YELLOW : LAMP_RED;
         assign move_d[3*gi +: 3] = (sel && state_d == ST_GREEN) ? MOVE_ALL : 3'b000;
      end
   endgenerate

   assign ped_walk_d = (state_d == ST_WALK) ? walk_bits_d : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_ALL_RED;
         dir_q       <= 3'd0;
         pend_q      <= '0;
         walk_bits_q <= '0;
         walk_done_q <= 1'b0;
         lamp_q      <= '0;
         move_q      <= '0;
         ped_walk_q  <= '0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         pend_q      <= pend_d;
         walk_bits_q <= walk_bits_d;
         walk_done_q <= walk_done_d;
         lamp_q      <= lamp_d;
         move_q      <= move_d;
         ped_walk_q  <= ped_walk_d;
      end
   end

`ifdef EMERG_PREEMPT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         pre_q     <= 1'b0;
         pre_dir_q <= 3'd0;
      end else begin
         pre_q     <= pre_d;
         pre_dir_q <= pre_dir_d;
      end
   end
`endif

   assign lamp       = lamp_q;
   assign move_en    = move_q;
   assign ped_walk   = ped_walk_q;
   assign active_dir = dir_q;

endmodule
